// File: rtl/cv_btn_fltr_pkg.sv
// Shared defaults and types for the cv_btn_fltr push-button debounce filter.
package cv_btn_fltr_pkg;

   localparam int unsigned DEF_FLTR_CYCLES = 16;
   localparam int unsigned DEF_CNT_W       = 16;
   localparam int unsigned SYNC_STAGES     = 2;

   typedef enum logic [1:0] {
      EDGE_NONE,
      EDGE_RISE,
      EDGE_FALL
   } edge_e;

endpackage

// File: rtl/cv_sync2.sv
// Generic flop-chain synchroniser (two stages by default), async active-high reset to 0.
module cv_sync2
   import cv_btn_fltr_pkg::*;
#(
   parameter int unsigned STAGES = SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cv_btn_fltr.sv
// Debounce filter: synchronised button level accepted after FLTR_CYCLES stable enabled cycles.
// Define CV_BTN_FLTR_BOTH_EDGES_EN to strobe BTN_CEO on release as well as press.
module cv_btn_fltr
   import cv_btn_fltr_pkg::*;
#(
   parameter int unsigned FLTR_CYCLES = DEF_FLTR_CYCLES,
   parameter int unsigned CNT_W       = DEF_CNT_W
) (
   input  logic CLK,
   input  logic RST,
   input  logic BTN_IN,
   input  logic CE,
   output logic BTN_OUT,
   output logic BTN_CEO
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLTR_CYCLES - 1);

   logic             btn_s;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             btn_out_q, btn_out_d;
   logic             btn_ceo_q, btn_ceo_d;
   edge_e            edge_d;

   cv_sync2 #(
      .STAGES(SYNC_STAGES)
   ) u_sync_btn (
      .clk(CLK),
      .rst(RST),
      .d  (BTN_IN),
      .q  (btn_s)
   );

   always_comb begin
      cnt_d     = cnt_q;
      btn_out_d = btn_out_q;
      edge_d    = EDGE_NONE;
      if (CE) begin
         if (btn_s == btn_out_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            btn_out_d = btn_s;
            edge_d    = btn_s ? EDGE_RISE : EDGE_FALL;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Strobe is registered alongside BTN_OUT so both change on the same edge.
   always_comb begin
`ifdef CV_BTN_FLTR_BOTH_EDGES_EN
      btn_ceo_d = (edge_d != EDGE_NONE);
`else
      btn_ceo_d = (edge_d == EDGE_RISE);
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q     <= '0;
         btn_out_q <= 1'b0;
         btn_ceo_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         btn_out_q <= btn_out_d;
         btn_ceo_q <= btn_ceo_d;
      end
   end

   assign BTN_OUT = btn_out_q;
   assign BTN_CEO = btn_ceo_q;

endmodule

// File: tb/tb_cv_btn_fltr.sv
// Self-checking bench for cv_btn_fltr: sliding-window reference model plus directed corner cases.
`timescale 1ns/100ps
module tb_cv_btn_fltr;

   localparam int unsigned F = 16;
`ifdef CV_BTN_FLTR_BOTH_EDGES_EN
   localparam bit BOTH = 1'b1;
`else
   localparam bit BOTH = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_in = 1'b0;
   logic ce = 1'b1;
   logic btn_out, btn_ceo;

   int checks = 0;
   int errors = 0;

   cv_btn_fltr #(
      .FLTR_CYCLES(F),
      .CNT_W      (16)
   ) dut (
      .CLK    (clk),
      .RST    (rst),
      .BTN_IN (btn_in),
      .CE     (ce),
      .BTN_OUT(btn_out),
      .BTN_CEO(btn_ceo)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the output flips once the last F enabled samples of the
   // synchronised input all differ from it; the window restarts after a flip.
   bit m_s1 = 0, m_s2 = 0, m_out = 0, m_ceo = 0;
   bit win[$];
   always @(posedge clk or posedge rst) begin
      bit s_now;
      bit flip;
      if (rst) begin
         m_s1 = 0; m_s2 = 0; m_out = 0; m_ceo = 0;
         win.delete();
      end else begin
         s_now = m_s2;
         m_s2  = m_s1;
         m_s1  = btn_in;
         m_ceo = 0;
         if (ce) begin
            win.push_back(s_now);
            if (win.size() > F) void'(win.pop_front());
            flip = (win.size() == F);
            foreach (win[i]) if (win[i] == m_out) flip = 0;
            if (flip) begin
               m_out = !m_out;
               m_ceo = m_out || BOTH;
               win.delete();
            end
         end
      end
   end

   int ceo_hi = 0, out_hi = 0, cyc = 0, ce_div = 1;
   always @(negedge clk) begin
      cyc++;
      check("out_vs_model", btn_out, m_out);
      check("ceo_vs_model", btn_ceo, m_ceo);
      if (btn_ceo) ceo_hi++;
      if (btn_out) out_hi++;
      ce = (ce_div == 0) ? ($urandom_range(0, 3) != 0) : ((cyc % ce_div) == 0);
   end

   task automatic wait_level(input logic lvl, output int n);
      n = 0;
      while (btn_out !== lvl && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   // Random 1 ns bounce, one clean opposite sample, then the final level held.
   task automatic bounce_to(input logic lvl, output int n);
      @(posedge clk);
      #5.5;
      repeat (50) begin
         btn_in = 1'($urandom_range(0, 1));
         #1;
      end
      btn_in = !lvl;
      #20;
      btn_in = lvl;
      wait_level(lvl, n);
   endtask

   typedef struct {
      int hi;
      int div;
      bit exp_out;
      int exp_ceo;
   } vec_t;

   vec_t vecs[7];

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      vecs[0] = '{1,  1, 1'b0, 0};
      vecs[1] = '{3,  1, 1'b0, 0};
      vecs[2] = '{15, 1, 1'b0, 0};
      vecs[3] = '{16, 1, 1'b1, BOTH ? 2 : 1};
      vecs[4] = '{17, 1, 1'b1, BOTH ? 2 : 1};
      vecs[5] = '{56, 4, 1'b0, 0};
      vecs[6] = '{72, 4, 1'b1, BOTH ? 2 : 1};

      // Reset held with the input toggling
      for (int i = 0; i < 14; i++) begin
         #7.3 btn_in = ~btn_in;
      end
      check("rst_out", btn_out, 1'b0);
      check("rst_ceo", btn_ceo, 1'b0);
      check_int("rst_out_hi", out_hi, 0);
      btn_in = 1'b0;
      @(posedge clk);
      #4 rst = 1'b0;
      repeat (30) @(posedge clk);
      check("idle_out", btn_out, 1'b0);

      // Pulse width / CE gating table
      for (int i = 0; i < 7; i++) begin
         ce_div = vecs[i].div;
         repeat (5) @(posedge clk);
         ceo_hi = 0;
         out_hi = 0;
         #5 btn_in = 1'b1;
         repeat (vecs[i].hi) @(posedge clk);
         #5 btn_in = 1'b0;
         repeat (120) @(posedge clk);
         check("vec_out_seen", out_hi > 0, vecs[i].exp_out);
         check_int("vec_ceo_cycles", ceo_hi, vecs[i].exp_ceo);
         check("vec_final_out", btn_out, 1'b0);
      end
      ce_div = 1;
      repeat (5) @(posedge clk);

      // Bounced press and release
      ceo_hi = 0;
      bounce_to(1'b1, n);
      check_int("press_latency", n, 18);
      repeat (12) @(posedge clk);
      check_int("press_ceo_cycles", ceo_hi, 1);
      ceo_hi = 0;
      bounce_to(1'b0, n);
      check_int("release_latency", n, 18);
      repeat (12) @(posedge clk);
      check_int("release_ceo_cycles", ceo_hi, BOTH ? 1 : 0);

      // Reset mid-count, then reset with the output already high
      @(posedge clk);
      #5 btn_in = 1'b1;
      repeat (12) @(posedge clk);
      #4 rst = 1'b1;
      #1 check("midcnt_rst_out", btn_out, 1'b0);
      @(posedge clk);
      #4 rst = 1'b0;
      ceo_hi = 0;
      wait_level(1'b1, n);
      check_int("rerelease_latency", n, 18);
      repeat (5) @(posedge clk);
      check_int("rerelease_ceo_cycles", ceo_hi, 1);
      #3 rst = 1'b1;
      #1 check("rst_high_out", btn_out, 1'b0);
      check("rst_high_ceo", btn_ceo, 1'b0);
      @(posedge clk);
      #4 rst = 1'b0;
      ceo_hi = 0;
      wait_level(1'b1, n);
      check_int("held_reaccept_latency", n, 18);
      repeat (5) @(posedge clk);
      check_int("held_reaccept_ceo", ceo_hi, 1);
      #5 btn_in = 1'b0;
      repeat (40) @(posedge clk);

      // Random levels with random hold times and random CE
      ce_div = 0;
      for (int i = 0; i < 150; i++) begin
         #5 btn_in = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 40)) @(posedge clk);
      end
      ce_div = 1;
      repeat (10) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
